cpu_bus_block_reader: RTL and testbench



---
 rtl/cpu_bus_reader_pkg.sv | 14 +
 rtl/cpu_bus_reader_fifo.sv | 74 +++++++
 rtl/cpu_bus_block_reader.sv | 162 ++++++++++++++++
 tb/tb_cpu_bus_block_reader.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_bus_reader_pkg.sv
// rtl/cpu_bus_reader_pkg.sv - shared types and constants for the CPU bus block reader
package cpu_bus_reader_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_ACK = 2'd2,
        DRAIN    = 2'd3
    } e_reader_state;

    localparam logic [31:0] BUS_WORD_BYTES = 32'd4;
    localparam logic [3:0]  BUS_READ_MASK  = 4'b0000;

endpackage

// File: rtl/cpu_bus_reader_fifo.sv
// rtl/cpu_bus_reader_fifo.sv - first-word fall-through FIFO buffering read words
//
// Ports:
//   clk, reset_n         clock, asynchronous active-low reset
//   push, push_data      write a word (ignored when full)
//   pop                  consume the head word (ignored when empty)
//   flush                discard all contents
//   pop_data             head word, forced to 0 while empty
//   full, empty, count   occupancy status
module cpu_bus_reader_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Head word is shown directly from storage; zero while empty keeps the
    // output quiet after reset and flush.
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (!do_push && do_pop) begin
                count <= count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/cpu_bus_block_reader.sv
// rtl/cpu_bus_block_reader.sv - reads N consecutive words over the CPU bus into a stream
//
// Ports:
//   clk, reset_n                      clock, asynchronous active-low reset
//   start, start_address, word_count  transfer command (accepted only when idle)
//   busy, done, error                 transfer status (done pulses, error is sticky)
//   out_valid, out_ready, out_data    output word stream
//   bus_request, bus_address          one-cycle read request and its word address
//   bus_wdata, bus_wmask              tied off for read accesses
//   bus_ack, bus_rdata                responder acknowledge and read data
module cpu_bus_block_reader
    import cpu_bus_reader_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int COUNT_WIDTH    = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [31:0]            start_address,
    input  logic [COUNT_WIDTH-1:0] word_count,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_data,
    output logic                   bus_request,
    output logic [31:0]            bus_address,
    output logic [31:0]            bus_wdata,
    output logic [3:0]             bus_wmask,
    input  logic                   bus_ack,
    input  logic [31:0]            bus_rdata
);

    localparam int          FIFO_CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    e_reader_state          state_q, state_d;
    logic [31:0]            addr_q, addr_d;
    logic [COUNT_WIDTH-1:0] remaining_q, remaining_d;
    logic [15:0]            timer_q, timer_d;
    logic                   error_q, error_d;
    logic                   done_q, done_d;

    logic                   fifo_push;
    logic                   fifo_pop;
    logic                   fifo_flush;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [FIFO_CW-1:0]     fifo_count;

    cpu_bus_reader_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (fifo_push),
        .push_data (bus_rdata),
        .pop       (fifo_pop),
        .flush     (fifo_flush),
        .pop_data  (out_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign out_valid   = !fifo_empty;
    assign fifo_pop    = out_valid && out_ready;
    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign error       = error_q;
    assign bus_address = addr_q;
    assign bus_wdata   = '0;
    assign bus_wmask   = BUS_READ_MASK;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            timer_q     <= '0;
            error_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            timer_q     <= timer_d;
            error_q     <= error_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        timer_d     = timer_q;
        error_d     = error_q;
        done_d      = 1'b0;
        bus_request = 1'b0;
        fifo_push   = 1'b0;
        fifo_flush  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    // Low address bits are dropped: accesses are always word aligned.
                    addr_d      = start_address & ~32'h3;
                    remaining_d = word_count;
                    error_d     = 1'b0;
                    if (word_count == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end

            ISSUE: begin
                // Only request when the returning word is guaranteed a slot.
                if (!fifo_full) begin
                    bus_request = 1'b1;
                    timer_d     = '0;
                    state_d     = WAIT_ACK;
                end
            end

            WAIT_ACK: begin
                if (bus_ack) begin
                    fifo_push   = 1'b1;
                    addr_d      = addr_q + BUS_WORD_BYTES;
                    remaining_d = remaining_q - COUNT_WIDTH'(1);
                    state_d     = (remaining_q > COUNT_WIDTH'(1)) ? ISSUE : DRAIN;
                end else if (timer_q == TIMEOUT_LAST) begin
                    error_d    = 1'b1;
                    fifo_flush = 1'b1;
                    state_d    = IDLE;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end

            DRAIN: begin
                // Finish as soon as the last buffered word leaves, even if it
                // is being popped right now.
                if (fifo_empty || (fifo_count == FIFO_CW'(1) && fifo_pop)) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_bus_block_reader.sv
// tb/tb_cpu_bus_block_reader.sv - self-checking bench for cpu_bus_block_reader
module tb_cpu_bus_block_reader;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] start_address = '0;
    logic [15:0] word_count = '0;
    logic        out_ready = 1'b0;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = '0;

    logic        busy, done, error, out_valid, bus_request;
    logic [31:0] out_data, bus_address, bus_wdata;
    logic [3:0]  bus_wmask;

    cpu_bus_block_reader #(
        .FIFO_DEPTH     (4),
        .TIMEOUT_CYCLES (255),
        .COUNT_WIDTH    (16)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .start_address (start_address),
        .word_count    (word_count),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .bus_request   (bus_request),
        .bus_address   (bus_address),
        .bus_wdata     (bus_wdata),
        .bus_wmask     (bus_wmask),
        .bus_ack       (bus_ack),
        .bus_rdata     (bus_rdata)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          req_count = 0;
    int          done_count = 0;
    bit          resp_enable = 1'b1;
    int          resp_delay = 1;
    int          pend_cnt = 0;
    logic [31:0] pend_addr = '0;
    logic [31:0] sb[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Responder: acks resp_delay cycles after a request, returning the address as data.
    always @(negedge clk) begin
        bus_ack = 1'b0;
        if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                bus_ack   = 1'b1;
                bus_rdata = pend_addr;
            end
        end
        if (bus_request) begin
            req_count++;
            if (resp_enable) begin
                pend_addr = bus_address;
                pend_cnt  = resp_delay;
            end
        end
    end

    // Output monitor: scoreboard pop on every accepted word, done bookkeeping.
    always @(negedge clk) begin
        if (reset_n) begin
            if (done) begin
                done_count++;
                check("done_busy", {31'd0, busy}, 32'd0);
            end
            if (out_valid && out_ready) begin
                check("sb_has_entry", {31'd0, sb.size() != 0}, 32'd1);
                if (sb.size() != 0) begin
                    check("out_data", out_data, sb.pop_front());
                end
            end
        end
    end

    task automatic run_start(input logic [31:0] addr, input logic [15:0] cnt, input bit expect_words);
        start_address = addr;
        word_count    = cnt;
        if (expect_words) begin
            for (int i = 0; i < int'(cnt); i++) begin
                sb.push_back((addr & ~32'h3) + 32'(4 * i));
            end
        end
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int limit);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        check(tag, {31'd0, seen}, 32'd1);
    endtask

    int  r0, d0, k;
    bit  in_window;

    initial begin
        // Reset state
        repeat (3) step();
        check("rst_busy",     {31'd0, busy},        32'd0);
        check("rst_done",     {31'd0, done},        32'd0);
        check("rst_error",    {31'd0, error},       32'd0);
        check("rst_valid",    {31'd0, out_valid},   32'd0);
        check("rst_request",  {31'd0, bus_request}, 32'd0);
        check("rst_out_data", out_data,             32'd0);
        check("rst_address",  bus_address,          32'd0);
        check("rst_wdata",    bus_wdata,            32'd0);
        check("rst_wmask",    {28'd0, bus_wmask},   32'd0);
        reset_n = 1'b1;
        step();

        // Basic read of 4 words
        r0 = req_count; d0 = done_count;
        out_ready = 1'b1;
        run_start(32'h0000_0010, 16'd4, 1'b1);
        check("basic_busy", {31'd0, busy}, 32'd1);
        wait_done("basic_done_seen", 200);
        step();
        check("basic_requests", 32'(req_count - r0), 32'd4);
        check("basic_done_cnt", 32'(done_count - d0), 32'd1);
        check("basic_error",    {31'd0, error}, 32'd0);
        check("basic_sb_empty", 32'(sb.size()), 32'd0);
        check("basic_idle",     {31'd0, busy}, 32'd0);

        // Backpressure: 8 words with the consumer stalled
        r0 = req_count; d0 = done_count;
        out_ready = 1'b0;
        run_start(32'h0000_0100, 16'd8, 1'b1);
        repeat (30) step();
        check("bp_requests_stalled", 32'(req_count - r0), 32'd4);
        check("bp_valid",            {31'd0, out_valid}, 32'd1);
        check("bp_busy",             {31'd0, busy}, 32'd1);
        check("bp_no_done",          32'(done_count - d0), 32'd0);
        out_ready = 1'b1;
        wait_done("bp_done_seen", 300);
        check("bp_all_popped_at_done", 32'(sb.size()), 32'd0);
        step();
        check("bp_requests", 32'(req_count - r0), 32'd8);
        check("bp_done_cnt", 32'(done_count - d0), 32'd1);

        // Zero-length transfer
        r0 = req_count;
        run_start(32'h0000_0040, 16'd0, 1'b0);
        check("zero_done", {31'd0, done}, 32'd1);
        check("zero_busy", {31'd0, busy}, 32'd0);
        step();
        check("zero_done_pulse", {31'd0, done}, 32'd0);
        repeat (5) step();
        check("zero_requests", 32'(req_count - r0), 32'd0);

        // Address wrap with unaligned start
        r0 = req_count;
        run_start(32'hFFFF_FFFD, 16'd2, 1'b1);
        wait_done("wrap_done_seen", 100);
        step();
        check("wrap_requests", 32'(req_count - r0), 32'd2);
        check("wrap_sb_empty", 32'(sb.size()), 32'd0);

        // Start while busy is ignored
        r0 = req_count;
        run_start(32'h0000_0200, 16'd3, 1'b1);
        step();
        step();
        start_address = 32'h0000_0900;
        word_count    = 16'd5;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done("ign_done_seen", 100);
        repeat (3) step();
        check("ign_requests", 32'(req_count - r0), 32'd3);
        check("ign_sb_empty", 32'(sb.size()), 32'd0);

        // Timeout with no responder
        resp_enable = 1'b0;
        d0 = done_count;
        run_start(32'h0000_0300, 16'd2, 1'b0);
        k = 0;
        while (!bus_request && k < 10) begin
            step();
            k++;
        end
        check("to_request_seen", {31'd0, bus_request}, 32'd1);
        k = 0;
        while (!error && k < 400) begin
            step();
            k++;
        end
        in_window = (k >= 255) && (k <= 256);
        check("to_error_latency", {31'd0, in_window}, 32'd1);
        check("to_busy",  {31'd0, busy}, 32'd0);
        check("to_valid", {31'd0, out_valid}, 32'd0);
        check("to_no_done", 32'(done_count - d0), 32'd0);
        repeat (10) step();
        pend_addr = 32'hDEAD_BEEF;
        pend_cnt  = 1;
        repeat (3) step();
        check("late_ack_valid", {31'd0, out_valid}, 32'd0);
        check("late_ack_busy",  {31'd0, busy}, 32'd0);
        check("error_sticky",   {31'd0, error}, 32'd1);
        resp_enable = 1'b1;
        run_start(32'h0000_0310, 16'd1, 1'b1);
        check("error_cleared", {31'd0, error}, 32'd0);
        wait_done("after_to_done_seen", 100);
        step();
        check("after_to_sb_empty", 32'(sb.size()), 32'd0);

        // Reset while waiting for ack
        resp_delay = 20;
        run_start(32'h0000_0400, 16'd4, 1'b1);
        repeat (5) step();
        check("mid_busy", {31'd0, busy}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_busy",    {31'd0, busy}, 32'd0);
        check("mid_rst_request", {31'd0, bus_request}, 32'd0);
        check("mid_rst_valid",   {31'd0, out_valid}, 32'd0);
        check("mid_rst_address", bus_address, 32'd0);
        check("mid_rst_done",    {31'd0, done}, 32'd0);
        sb.delete();
        pend_cnt   = 0;
        resp_delay = 1;
        step();
        step();
        reset_n = 1'b1;
        step();
        r0 = req_count;
        run_start(32'h0000_0500, 16'd2, 1'b1);
        wait_done("post_rst_done_seen", 100);
        step();
        check("post_rst_requests", 32'(req_count - r0), 32'd2);
        check("post_rst_sb_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
